seq_pattern_gen: RTL and testbench
==================================

SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 Parameter: DWELL, default 4, clock cycles each pattern step is held; legal range 1..2^26.
REQ-003 Parameter: DW, default 27, width of the dwell counter; SHALL satisfy 2^DW > DWELL.
REQ-004 clk_pin  input  1  system clock; all state changes on its rising edge.
REQ-005 rst_pin  input  1  synchronous active-high reset.
REQ-006 sw_pin  input  8  [0]=start (level; rising edge triggers), [1]=abort (level), [2]=mode (0 good pattern, 1 bad pattern), [7:3] unused.
REQ-007 x2_out  output  1  generated pattern bit x2, registered.
REQ-008 x1_out  output  1  generated pattern bit x1, registered.
REQ-009 busy  output  1  high while a sequence is being emitted.
REQ-010 done  output  1  sticky completion flag.
REQ-011 led_pin  output  16  [7]=x2_out, [6]=x1_out, [1:0]=step code, [15]=busy, [14]=done, [13:10]=pass count, all others 0.

Function
REQ-012 The block SHALL generate the x2/x1 stimulus for the 00->10->11 sequence detector; mode=1 SHALL emit 00->10->01 instead, a negative case the detector must reject.
REQ-013 sw_pin[2:0] SHALL be registered once (sw_q), with a second register (sw_qq) on bit 0; start_edge = sw_q[0] & ~sw_qq[0].
REQ-014 FSM states: IDLE, S00, S10, S11, DONE; step code on led_pin[1:0]: IDLE/DONE=00, S00=01, S10=10, S11=11.
REQ-015 Outputs per state: IDLE/S00/DONE -> x2,x1=00; S10 -> 10; S11 -> 11 when mode=0, 01 when mode=1.
REQ-016 mode SHALL be latched on the cycle start_edge is accepted and held constant for the whole sequence.
REQ-017 IDLE or DONE with start_edge and no abort -> S00, dwell counter cleared, busy=1, done=0.
REQ-018 A rising edge of sw_pin[0] SHALL raise busy and enter S00 exactly 2 clk_pin edges later.
REQ-019 In S00/S10/S11 the counter SHALL increment each cycle; at count==DWELL-1 it clears and the FSM advances S00->S10->S11->DONE, so each step lasts exactly DWELL cycles.
REQ-020 Entering DONE SHALL set done=1 and busy=0 on the same edge; done holds until the next accepted start, an abort, or reset.
REQ-021 start_edge while busy SHALL be ignored, with no restart and no mode change.
REQ-022 sw_q[1]=1 in any state SHALL force IDLE on the next edge: outputs 00, busy=0, done=0, counter cleared; pass count unchanged.
REQ-023 Simultaneous abort and start_edge: abort wins and the sequence does not start.
REQ-024 Pass count SHALL increment by 1 on every completed S11 step, 4 bits, wrapping 15->0.
REQ-025 All outputs SHALL be registered, with no combinational path from sw_pin to any output.

Reset
REQ-026 rst_pin=1 at a clock edge SHALL force IDLE, x2_out=x1_out=0, busy=0, done=0, pass count=0, counter=0, sw_q=sw_qq=0, latched mode=0.
REQ-027 Reset SHALL take priority over abort and start, including mid-sequence; the first start_edge can be accepted on the first edge after rst_pin falls.

Configuration
REQ-028 Macro SEQGEN_LOOP_EN: when defined, S11 completion SHALL go to S00 instead of DONE and looping continues until abort or reset; done never asserts and pass count increments per loop.
REQ-029 Without SEQGEN_LOOP_EN the block is one-shot per REQ-019/020, and DONE logic plus the pass counter still exist.

Verification
REQ-030 DWELL=4, reset, sw_pin[0] 0->1 at cycle 0 -> busy=1 from edge 2; x2x1=00 for edges 2-5, 10 for 6-9, 11 for 10-13; done=1, busy=0 at edge 14; pass count=1.
REQ-031 Same stimulus with mode=1 -> third step x2x1=01 for 4 cycles; done=1; mode toggled mid-run has no effect.
REQ-032 Abort asserted during S10 -> next edge x2x1=00, busy=0, done=0, led_pin[1:0]=00; a later start runs the full 12-cycle sequence.
REQ-033 Second start edge during S10 -> ignored, sequence ends at the original cycle; abort and start edge in the same cycle from IDLE -> stays IDLE.
REQ-034 rst_pin pulsed during S11 -> all outputs 0 next edge; 16 completed runs -> pass count wraps to 0.
REQ-035 With SEQGEN_LOOP_EN defined and DWELL=1 -> pattern 00,10,11 repeats every 3 cycles; done stays 0; pass count increments every 3 cycles until abort.

Source files
------------

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: drives the x2/x1 stimulus for a 00->10->11 sequence detector.
// mode=1 emits 00->10->01 instead, a sequence the detector must reject.
// Each step is held for DWELL cycles.
// Optional feature: define SEQGEN_LOOP_EN to repeat the sequence until abort or reset
// instead of stopping in DONE.
module seq_pattern_gen #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned DW    = 27
) (
  input  logic        clk_pin,
  input  logic        rst_pin,
  input  logic [7:0]  sw_pin,
  output logic        x2_out,
  output logic        x1_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] led_pin
);

  typedef enum logic [2:0] {StIdle, StS00, StS10, StS11, StDone} state_e;

  localparam logic [DW-1:0] CntLast = DW'(DWELL - 1);

  state_e        state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [2:0]    sw_q;
  logic          sw_qq;
  logic          mode_q, mode_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [3:0]    pass_q, pass_d;
  logic          x2_q, x2_d;
  logic          x1_q, x1_d;
  logic [1:0]    step_q, step_d;
  logic          start_edge;
  logic          abort;
  logic          unused_sw;

  assign unused_sw  = ^sw_pin[7:3];
  assign start_edge = sw_q[0] & ~sw_qq;
  assign abort      = sw_q[1];

  // Input synchronisers, FSM state and registered outputs.
  always_ff @(posedge clk_pin) begin
    if (rst_pin) begin
      sw_q    <= 3'b000;
      sw_qq   <= 1'b0;
      state_q <= StIdle;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 4'd0;
      x2_q    <= 1'b0;
      x1_q    <= 1'b0;
      step_q  <= 2'b00;
    end else begin
      sw_q    <= sw_pin[2:0];
      sw_qq   <= sw_q[0];
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      x2_q    <= x2_d;
      x1_q    <= x1_d;
      step_q  <= step_d;
    end
  end

  // Next-state logic; abort overrides everything except reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    if (abort) begin
      state_d = StIdle;
      cnt_d   = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start_edge) begin
            state_d = StS00;
            cnt_d   = '0;
            mode_d  = sw_q[2];
            busy_d  = 1'b1;
            done_d  = 1'b0;
          end
        end
        StS00, StS10, StS11: begin
          if (cnt_q == CntLast) begin
            cnt_d = '0;
            if (state_q == StS00) begin
              state_d = StS10;
            end else if (state_q == StS10) begin
              state_d = StS11;
            end else begin
              pass_d = pass_q + 4'd1;
`ifdef SEQGEN_LOOP_EN
              state_d = StS00;
`else
              state_d = StDone;
              busy_d  = 1'b0;
              done_d  = 1'b1;
`endif
            end
          end else begin
            cnt_d = cnt_q + DW'(1);
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  // Pattern bits and step code decoded from the next state so they land in flops.
  always_comb begin
    x2_d   = 1'b0;
    x1_d   = 1'b0;
    step_d = 2'b00;
    unique case (state_d)
      StS00: step_d = 2'b01;
      StS10: begin
        step_d = 2'b10;
        x2_d   = 1'b1;
      end
      StS11: begin
        step_d = 2'b11;
        x2_d   = ~mode_d;
        x1_d   = 1'b1;
      end
      default: step_d = 2'b00;
    endcase
  end

  assign x2_out  = x2_q;
  assign x1_out  = x1_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign led_pin = {busy_q, done_q, pass_q, 2'b00, x2_q, x1_q, 4'b0000, step_q};

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen against a timeline-based reference model.
module tb_seq_pattern_gen;

  localparam int unsigned DWELL = 4;

  logic        clk_pin;
  logic        rst_pin;
  logic [7:0]  sw_pin;
  logic        x2_out;
  logic        x1_out;
  logic        busy;
  logic        done;
  logic [15:0] led_pin;

  int checks;
  int failures;

  // Reference model: a run is described by the edge it entered S00 (m_t0);
  // outputs follow from the elapsed edge count divided by DWELL.
  int         m_e;
  int         m_t0;
  logic       m_run;
  logic       m_done;
  logic       m_mode;
  logic [3:0] m_pass;
  logic [2:0] m_swq;
  logic       m_swqq;

  seq_pattern_gen #(.DWELL(DWELL), .DW(27)) dut (
    .clk_pin (clk_pin),
    .rst_pin (rst_pin),
    .sw_pin  (sw_pin),
    .x2_out  (x2_out),
    .x1_out  (x1_out),
    .busy    (busy),
    .done    (done),
    .led_pin (led_pin)
  );

  initial begin
    clk_pin = 1'b0;
    forever #5 clk_pin = ~clk_pin;
  end

  task automatic model_edge();
    logic abort;
    logic se;
    m_e   = m_e + 1;
    if (rst_pin) begin
      m_run  = 1'b0;
      m_done = 1'b0;
      m_mode = 1'b0;
      m_pass = 4'd0;
      m_swq  = 3'b000;
      m_swqq = 1'b0;
    end else begin
      abort = m_swq[1];
      se    = m_swq[0] & ~m_swqq;
      if (abort) begin
        m_run  = 1'b0;
        m_done = 1'b0;
      end else if (m_run) begin
        if (m_e - m_t0 == 3 * int'(DWELL)) begin
          m_pass = m_pass + 4'd1;
`ifdef SEQGEN_LOOP_EN
          m_t0 = m_e;
`else
          m_run  = 1'b0;
          m_done = 1'b1;
`endif
        end
      end else if (se) begin
        m_run  = 1'b1;
        m_t0   = m_e;
        m_mode = m_swq[2];
        m_done = 1'b0;
      end
      m_swqq = m_swq[0];
      m_swq  = sw_pin[2:0];
    end
  endtask

  // Expected {x2_out, x1_out, busy, done, led_pin}.
  function automatic logic [19:0] exp_vec();
    int         ph;
    logic       x2;
    logic       x1;
    logic [1:0] st;
    x2 = 1'b0;
    x1 = 1'b0;
    st = 2'b00;
    if (m_run) begin
      ph = (m_e - m_t0) / int'(DWELL);
      if (ph == 0) begin
        st = 2'b01;
      end else if (ph == 1) begin
        st = 2'b10;
        x2 = 1'b1;
      end else begin
        st = 2'b11;
        x2 = ~m_mode;
        x1 = 1'b1;
      end
    end
    return {x2, x1, m_run, m_done, m_run, m_done, m_pass, 2'b00, x2, x1, 4'b0000, st};
  endfunction

  function automatic logic [19:0] act_vec();
    return {x2_out, x1_out, busy, done, led_pin};
  endfunction

  task automatic tick(input logic r, input logic [7:0] s);
    rst_pin = r;
    sw_pin  = s;
    model_edge();
    @(posedge clk_pin);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 8'($urandom));
      checks++;
      if (act_vec() !== 20'h0) begin
        failures++;
        $display("FAIL reset cyc=%0d got=%h exp=%h", i, act_vec(), 20'h0);
      end
    end
    tick(1'b0, 8'h00);
    checks++;
    if (act_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL reset_release got=%h exp=%h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_good_seq();
    tick(1'b0, 8'h01);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL good_seq cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      end
      tick(1'b0, 8'h01);
    end
    checks++;
    if (led_pin[14] !== 1'b1 || busy !== 1'b0 || led_pin[13:10] !== 4'd1) begin
      failures++;
      $display("FAIL good_seq_end got=%h exp=done,pass1", led_pin);
    end
  endtask

  task automatic test_bad_mode();
    tick(1'b0, 8'h04);
    tick(1'b0, 8'h05);
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, (i > 5) ? 8'h01 : 8'h05);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL bad_mode cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_abort();
    tick(1'b0, 8'h00);
    tick(1'b0, 8'h01);
    for (int i = 0; i < 24; i++) begin
      tick(1'b0, (i == 7) ? 8'h03 : ((i > 10 && i < 13) ? 8'h00 : 8'h01));
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL abort cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s;
    tick(1'b0, 8'h00);
    tick(1'b0, 8'h01);
    for (int i = 0; i < 22; i++) begin
      // second start edge during S10, then abort+start together from IDLE
      if (i == 7) s = 8'h00;
      else if (i == 17) s = 8'h00;
      else if (i == 18) s = 8'h03;
      else s = 8'h01;
      tick(1'b0, s);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b0, 8'h00);
    tick(1'b0, 8'h01);
    for (int i = 0; i < 16; i++) begin
      tick((i == 11) ? 1'b1 : 1'b0, 8'h01);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL reset_mid cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_pass_wrap();
    for (int r = 0; r < 16; r++) begin
      tick(1'b0, 8'h00);
      for (int i = 0; i < 3 * int'(DWELL) + 3; i++) begin
        tick(1'b0, 8'h01);
        checks++;
        if (act_vec() !== exp_vec()) begin
          failures++;
          $display("FAIL pass_wrap run=%0d cyc=%0d got=%h exp=%h", r, i, act_vec(),
                   exp_vec());
        end
      end
    end
    checks++;
    if (led_pin[13:10] !== 4'd0) begin
      failures++;
      $display("FAIL pass_wrap_zero got=%0d exp=0", led_pin[13:10]);
    end
  endtask

  task automatic test_random();
    logic [7:0] s;
    logic       r;
    s = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) s[0] = ~s[0];
      s[1]   = ($urandom_range(0, 31) == 0);
      s[2]   = 1'($urandom);
      s[7:3] = 5'($urandom);
      r      = ($urandom_range(0, 127) == 0);
      tick(r, s);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_e      = 0;
    m_t0     = 0;
    m_run    = 1'b0;
    m_done   = 1'b0;
    m_mode   = 1'b0;
    m_pass   = 4'd0;
    m_swq    = 3'b000;
    m_swqq   = 1'b0;
    rst_pin  = 1'b1;
    sw_pin   = 8'h00;
    test_reset();
    test_good_seq();
    test_bad_mode();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_pass_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
